// File: rtl/frost_imem_loader_pkg.sv
// Shared types for the FROST instruction-memory loader: AXI response codes,
// write/read FSM state encodings and the memory word size.
package frost_imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_MEM,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_MEM,
    R_WAIT,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/image_load_reset_hold.sv
// Keeps the CPU in reset while an image streams in: every memory write reloads
// the counter, and the hold output stays high until the counter has drained.
module image_load_reset_hold #(
  parameter int unsigned HOLD_CYCLES = 134217727
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_cpu_rst_hold
);

  localparam int unsigned CNT_W = $clog2(longint'(HOLD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // A load wins over the decrement, so a write on the final count never lets hold glitch low.
  always_comb begin
    count_next = count;
    if (i_load) begin
      count_next = HOLD_INIT;
    end else if (count != '0) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count          <= '0;
      o_cpu_rst_hold <= 1'b0;
    end else begin
      count          <= count_next;
      o_cpu_rst_hold <= (count_next != '0);
    end
  end

endmodule

// File: rtl/axil_imem_loader.sv
// AXI4-Lite slave driving the FROST instruction-memory port plus the image-load CPU reset hold.
// Define IMEM_READBACK_EN to let AXI reads fetch memory contents; otherwise reads return SLVERR.
module axil_imem_loader
  import frost_imem_loader_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter int unsigned HOLD_CYCLES    = 134217727
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [31:0]               i_s_awaddr,
  input  logic                      i_s_awvalid,
  output logic                      o_s_awready,
  input  logic [31:0]               i_s_wdata,
  input  logic [3:0]                i_s_wstrb,
  input  logic                      i_s_wvalid,
  output logic                      o_s_wready,
  output logic [1:0]                o_s_bresp,
  output logic                      o_s_bvalid,
  input  logic                      i_s_bready,
  input  logic [31:0]               i_s_araddr,
  input  logic                      i_s_arvalid,
  output logic                      o_s_arready,
  output logic [31:0]               o_s_rdata,
  output logic [1:0]                o_s_rresp,
  output logic                      o_s_rvalid,
  input  logic                      i_s_rready,
  output logic                      o_mem_en,
  output logic [3:0]                o_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]               o_mem_wrdata,
  input  logic [31:0]               i_mem_rddata,
  output logic                      o_cpu_rst_hold
);

  localparam int unsigned ALIGN_BITS = $clog2(WORD_BYTES);

  wr_state_e   wr_state, wr_state_next;
  rd_state_e   rd_state, rd_state_next;
  logic        aw_held, w_held;
  logic [31:0] awaddr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  axi_resp_e   bresp_q, rresp_q;
  logic        aw_hs, w_hs, ar_hs;
  logic        wr_in_range, wr_mem_en, rd_mem_en;

  // Ready outputs are gated by reset so nothing is accepted while the FSMs are being cleared.
  assign o_s_awready = !i_rst && (wr_state == W_IDLE) && !aw_held;
  assign o_s_wready  = !i_rst && (wr_state == W_IDLE) && !w_held;
  assign o_s_arready = !i_rst && (rd_state == R_IDLE);
  assign o_s_bvalid  = (wr_state == W_RESP);
  assign o_s_rvalid  = (rd_state == R_RESP);
  assign o_s_bresp   = bresp_q;
  assign o_s_rresp   = rresp_q;
  assign o_s_rdata   = rdata_q;

  assign aw_hs       = i_s_awvalid && o_s_awready;
  assign w_hs        = i_s_wvalid && o_s_wready;
  assign ar_hs       = i_s_arvalid && o_s_arready;
  assign wr_in_range = ((awaddr_q >> MEM_ADDR_WIDTH) == 32'd0);

  always_comb begin
    wr_state_next = wr_state;
    wr_mem_en     = 1'b0;
    unique case (wr_state)
      W_IDLE: if ((aw_held || aw_hs) && (w_held || w_hs)) wr_state_next = W_MEM;
      W_MEM: begin
        wr_mem_en     = wr_in_range && (wstrb_q != 4'd0);
        wr_state_next = W_RESP;
      end
      W_RESP: if (i_s_bready) wr_state_next = W_IDLE;
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_state <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= OKAY;
    end else begin
      wr_state <= wr_state_next;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= i_s_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= i_s_wdata;
        wstrb_q <= i_s_wstrb;
      end
      if (wr_state == W_MEM) bresp_q <= wr_in_range ? OKAY : SLVERR;
      if (o_s_bvalid && i_s_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

`ifdef IMEM_READBACK_EN
  logic [31:0] araddr_q;
  logic        rd_in_range;

  assign rd_in_range = ((araddr_q >> MEM_ADDR_WIDTH) == 32'd0);

  // The write FSM owns the memory port in W_MEM; a read parked in R_MEM waits for it.
  always_comb begin
    rd_state_next = rd_state;
    rd_mem_en     = 1'b0;
    unique case (rd_state)
      R_IDLE: if (ar_hs) rd_state_next = R_MEM;
      R_MEM: begin
        if (!rd_in_range) begin
          rd_state_next = R_RESP;
        end else if (wr_state != W_MEM) begin
          rd_mem_en     = 1'b1;
          rd_state_next = R_WAIT;
        end
      end
      R_WAIT: rd_state_next = R_RESP;
      R_RESP: if (i_s_rready) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  assign o_mem_addr = wr_mem_en ? {awaddr_q[MEM_ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}}
                                : {araddr_q[MEM_ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
`else
  logic unused_rd;

  assign unused_rd = ^{i_s_araddr, i_mem_rddata};

  always_comb begin
    rd_state_next = rd_state;
    rd_mem_en     = 1'b0;
    unique case (rd_state)
      R_IDLE: if (ar_hs) rd_state_next = R_RESP;
      R_RESP: if (i_s_rready) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  assign o_mem_addr = {awaddr_q[MEM_ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
`endif

  // Each accepted read starts as a zero-data SLVERR; only a completed memory fetch upgrades it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
`ifdef IMEM_READBACK_EN
      araddr_q <= '0;
`endif
    end else begin
      rd_state <= rd_state_next;
      if (ar_hs) begin
        rdata_q <= '0;
        rresp_q <= SLVERR;
`ifdef IMEM_READBACK_EN
        araddr_q <= i_s_araddr;
`endif
      end
`ifdef IMEM_READBACK_EN
      if (rd_state == R_WAIT) begin
        rdata_q <= i_mem_rddata;
        rresp_q <= OKAY;
      end
`endif
    end
  end

  assign o_mem_en     = wr_mem_en || rd_mem_en;
  assign o_mem_we     = wr_mem_en ? wstrb_q : 4'd0;
  assign o_mem_wrdata = wdata_q;

  image_load_reset_hold #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_reset_hold (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_load        (wr_mem_en),
    .o_cpu_rst_hold(o_cpu_rst_hold)
  );

endmodule

// File: tb/tb_axil_imem_loader.sv
// Directed bench for axil_imem_loader: table-driven AXI writes plus hand sequences
// for the reset hold, B back-pressure, port arbitration and mid-transaction reset.
module tb_axil_imem_loader;
  import frost_imem_loader_pkg::*;

  localparam int unsigned MAW  = 16;
  localparam int unsigned HOLD = 8;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [31:0]    i_s_awaddr, i_s_wdata, i_s_araddr;
  logic [3:0]     i_s_wstrb;
  logic           i_s_awvalid, i_s_wvalid, i_s_bready, i_s_arvalid, i_s_rready;
  logic           o_s_awready, o_s_wready, o_s_bvalid, o_s_arready, o_s_rvalid;
  logic [1:0]     o_s_bresp, o_s_rresp;
  logic [31:0]    o_s_rdata, o_mem_wrdata;
  logic           o_mem_en, o_cpu_rst_hold;
  logic [3:0]     o_mem_we;
  logic [MAW-1:0] o_mem_addr;
  logic [31:0]    i_mem_rddata = '0;

  always #5 i_clk = ~i_clk;

  axil_imem_loader #(
    .MEM_ADDR_WIDTH(MAW),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_s_awaddr(i_s_awaddr), .i_s_awvalid(i_s_awvalid), .o_s_awready(o_s_awready),
    .i_s_wdata(i_s_wdata), .i_s_wstrb(i_s_wstrb), .i_s_wvalid(i_s_wvalid), .o_s_wready(o_s_wready),
    .o_s_bresp(o_s_bresp), .o_s_bvalid(o_s_bvalid), .i_s_bready(i_s_bready),
    .i_s_araddr(i_s_araddr), .i_s_arvalid(i_s_arvalid), .o_s_arready(o_s_arready),
    .o_s_rdata(o_s_rdata), .o_s_rresp(o_s_rresp), .o_s_rvalid(o_s_rvalid), .i_s_rready(i_s_rready),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wrdata(o_mem_wrdata), .i_mem_rddata(i_mem_rddata), .o_cpu_rst_hold(o_cpu_rst_hold)
  );

  int checks   = 0;
  int failures = 0;

  // Memory model with one-cycle read latency, plus a record of every port pulse.
  logic [31:0] mem [0:(2**(MAW-2))-1];
  int          pulses = 0;
  logic [3:0]  last_we;
  logic [31:0] last_addr, last_wrdata;

  initial for (int i = 0; i < 2**(MAW-2); i++) mem[i] = '0;

  always @(posedge i_clk) begin
    if (o_mem_en) begin
      pulses++;
      last_we     = o_mem_we;
      last_addr   = 32'(o_mem_addr);
      last_wrdata = o_mem_wrdata;
      for (int b = 0; b < 4; b++)
        if (o_mem_we[b]) mem[o_mem_addr[MAW-1:2]][b*8 +: 8] = o_mem_wrdata[b*8 +: 8];
      i_mem_rddata <= mem[o_mem_addr[MAW-1:2]];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          wdly;
    int          exp_pulses;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr;
    logic [1:0]  exp_resp;
  } wr_vec_t;

  wr_vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int wdly, output logic [1:0] resp, output logic ok);
    logic aw_done, w_done, aw_hs, w_hs;
    aw_done = 1'b0;
    w_done  = 1'b0;
    i_s_awaddr = addr;
    i_s_wdata  = data;
    i_s_wstrb  = strb;
    for (int k = 0; k < 40 && !(aw_done && w_done); k++) begin
      i_s_awvalid = !aw_done;
      i_s_wvalid  = !w_done && (k >= wdly);
      aw_hs = i_s_awvalid && o_s_awready;
      w_hs  = i_s_wvalid && o_s_wready;
      step();
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
    end
    i_s_awvalid = 1'b0;
    i_s_wvalid  = 1'b0;
    i_s_bready  = 1'b1;
    resp = '0;
    ok   = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (o_s_bvalid) begin
        resp = o_s_bresp;
        ok   = 1'b1;
      end
      step();
    end
    i_s_bready = 1'b0;
  endtask

  task automatic applyRead(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output logic ok);
    logic done;
    done = 1'b0;
    i_s_araddr = addr;
    for (int k = 0; k < 40 && !done; k++) begin
      i_s_arvalid = 1'b1;
      done = o_s_arready;
      step();
    end
    i_s_arvalid = 1'b0;
    i_s_rready  = 1'b1;
    ok = 1'b0;
    data = '0;
    resp = '0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (o_s_rvalid) begin
        data = o_s_rdata;
        resp = o_s_rresp;
        ok   = 1'b1;
      end
      step();
    end
    i_s_rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        ok;
    int          p0;

    vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 2, 1, 4'hF, 32'h0100, 2'b00};
    vecs[1] = '{32'h0000_0203, 32'h1234_5678, 4'h3, 0, 1, 4'h3, 32'h0200, 2'b00};
    vecs[2] = '{32'h0000_FFFC, 32'hA5A5_A5A5, 4'h8, 1, 1, 4'h8, 32'hFFFC, 2'b00};
    vecs[3] = '{32'h0001_0000, 32'h1111_1111, 4'hF, 0, 0, 4'h0, 32'h0000, 2'b10};
    vecs[4] = '{32'h0000_0040, 32'h2222_2222, 4'h0, 0, 0, 4'h0, 32'h0000, 2'b00};
    vecs[5] = '{32'h8000_0000, 32'h3333_3333, 4'hF, 3, 0, 4'h0, 32'h0000, 2'b10};

    i_rst = 1'b1;
    i_s_awaddr = '0; i_s_wdata = '0; i_s_wstrb = '0; i_s_araddr = '0;
    i_s_awvalid = 1'b0; i_s_wvalid = 1'b0; i_s_bready = 1'b0;
    i_s_arvalid = 1'b0; i_s_rready = 1'b0;
    repeat (3) step();

    checkOutput("rst_awready", o_s_awready, 1'b0);
    checkOutput("rst_wready", o_s_wready, 1'b0);
    checkOutput("rst_arready", o_s_arready, 1'b0);
    checkOutput("rst_bvalid", o_s_bvalid, 1'b0);
    checkOutput("rst_rvalid", o_s_rvalid, 1'b0);
    checkOutput("rst_mem_en", o_mem_en, 1'b0);
    checkOutput("rst_mem_we", o_mem_we, 4'h0);
    checkOutput("rst_bresp", o_s_bresp, 2'b00);
    checkOutput("rst_rresp", o_s_rresp, 2'b00);
    checkOutput("rst_rdata", o_s_rdata, 32'h0);
    checkOutput("rst_hold", o_cpu_rst_hold, 1'b0);

    i_rst = 1'b0;
    step();
    checkOutput("idle_awready", o_s_awready, 1'b1);
    checkOutput("idle_wready", o_s_wready, 1'b1);
    checkOutput("idle_arready", o_s_arready, 1'b1);

    for (int v = 0; v < 6; v++) begin
      p0 = pulses;
      applyStimulus(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].wdly, resp, ok);
      checkOutput($sformatf("vec%0d_done", v), ok, 1'b1);
      checkOutput($sformatf("vec%0d_bresp", v), resp, vecs[v].exp_resp);
      checkOutput($sformatf("vec%0d_pulses", v), pulses - p0, vecs[v].exp_pulses);
      if (vecs[v].exp_pulses == 1) begin
        checkOutput($sformatf("vec%0d_we", v), last_we, vecs[v].exp_we);
        checkOutput($sformatf("vec%0d_addr", v), last_addr, vecs[v].exp_addr);
        checkOutput($sformatf("vec%0d_wrdata", v), last_wrdata, vecs[v].data);
      end
    end

    // Out-of-range write with the hold counter idle must not start a hold.
    repeat (12) step();
    checkOutput("hold_idle", o_cpu_rst_hold, 1'b0);
    p0 = pulses;
    applyStimulus(32'h0001_0000, 32'h4444_4444, 4'hF, 0, resp, ok);
    checkOutput("oor_bresp", resp, 2'b10);
    checkOutput("oor_pulses", pulses - p0, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("oor_hold", o_cpu_rst_hold, 1'b0);
      step();
    end

    // Two writes five cycles apart: hold stays high, then drops HOLD cycles after the second.
    i_s_bready  = 1'b1;
    i_s_awaddr  = 32'h300; i_s_wdata = 32'h0BAD_F00D; i_s_wstrb = 4'hF;
    i_s_awvalid = 1'b1; i_s_wvalid = 1'b1;
    step();
    i_s_awvalid = 1'b0; i_s_wvalid = 1'b0;
    checkOutput("hold_w1_en", o_mem_en, 1'b1);
    checkOutput("hold_w1_before", o_cpu_rst_hold, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      checkOutput($sformatf("hold_gap_%0d", k), o_cpu_rst_hold, 1'b1);
      if (k == 4) begin
        i_s_awaddr = 32'h304; i_s_awvalid = 1'b1; i_s_wvalid = 1'b1;
      end
      if (k == 5) begin
        i_s_awvalid = 1'b0; i_s_wvalid = 1'b0;
        checkOutput("hold_w2_en", o_mem_en, 1'b1);
      end
    end
    for (int k = 1; k <= HOLD; k++) begin
      step();
      checkOutput($sformatf("hold_after_%0d", k), o_cpu_rst_hold, 1'b1);
    end
    step();
    checkOutput("hold_release", o_cpu_rst_hold, 1'b0);
    i_s_bready = 1'b0;

    // W before AW, with B held off for five cycles.
    p0 = pulses;
    i_s_wdata = 32'h5566_7788; i_s_wstrb = 4'hF; i_s_wvalid = 1'b1;
    step();
    i_s_wvalid = 1'b0;
    checkOutput("wfirst_wready", o_s_wready, 1'b0);
    checkOutput("wfirst_awready", o_s_awready, 1'b1);
    step();
    step();
    i_s_awaddr = 32'h104; i_s_awvalid = 1'b1;
    step();
    i_s_awvalid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_bvalid", o_s_bvalid, 1'b1);
      checkOutput("bp_awready", o_s_awready, 1'b0);
      checkOutput("bp_wready", o_s_wready, 1'b0);
      step();
    end
    checkOutput("bp_pulses", pulses - p0, 1);
    checkOutput("bp_addr", last_addr, 32'h104);
    checkOutput("bp_bresp", o_s_bresp, 2'b00);
    i_s_bready = 1'b1;
    step();
    i_s_bready = 1'b0;
    checkOutput("bp_bvalid_clear", o_s_bvalid, 1'b0);

    // Write and read launched together: write owns the port first.
    i_s_awaddr = 32'h400; i_s_wdata = 32'hCAFE_F00D; i_s_wstrb = 4'hF;
    i_s_araddr = 32'h400; i_s_bready = 1'b1;
    i_s_awvalid = 1'b1; i_s_wvalid = 1'b1; i_s_arvalid = 1'b1;
    step();
    i_s_awvalid = 1'b0; i_s_wvalid = 1'b0; i_s_arvalid = 1'b0;
    checkOutput("arb_w_en", o_mem_en, 1'b1);
    checkOutput("arb_w_we", o_mem_we, 4'hF);
    checkOutput("arb_w_addr", o_mem_addr, 16'h0400);
    step();
    checkOutput("arb_bvalid", o_s_bvalid, 1'b1);
`ifdef IMEM_READBACK_EN
    checkOutput("arb_r_en", o_mem_en, 1'b1);
    checkOutput("arb_r_we", o_mem_we, 4'h0);
    checkOutput("arb_r_addr", o_mem_addr, 16'h0400);
`endif
    i_s_rready = 1'b1;
    ok = 1'b0; rdata = '0; resp = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (o_s_rvalid) begin
        rdata = o_s_rdata; resp = o_s_rresp; ok = 1'b1;
      end
      step();
    end
    i_s_rready = 1'b0;
    i_s_bready = 1'b0;
    checkOutput("arb_r_done", ok, 1'b1);
`ifdef IMEM_READBACK_EN
    checkOutput("arb_rdata", rdata, 32'hCAFE_F00D);
    checkOutput("arb_rresp", resp, 2'b00);
`else
    checkOutput("arb_rdata", rdata, 32'h0);
    checkOutput("arb_rresp", resp, 2'b10);
`endif

    applyRead(32'h0001_0000, rdata, resp, ok);
    checkOutput("oor_read_done", ok, 1'b1);
    checkOutput("oor_read_rdata", rdata, 32'h0);
    checkOutput("oor_read_rresp", resp, 2'b10);

    // Reset while a response is pending drops it; the next write still completes.
    repeat (12) step();
    i_s_awaddr = 32'h500; i_s_wdata = 32'h9999_0000; i_s_wstrb = 4'hF;
    i_s_awvalid = 1'b1; i_s_wvalid = 1'b1;
    step();
    i_s_awvalid = 1'b0; i_s_wvalid = 1'b0;
    step();
    checkOutput("mid_bvalid", o_s_bvalid, 1'b1);
    checkOutput("mid_hold", o_cpu_rst_hold, 1'b1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    checkOutput("mid_rst_bvalid", o_s_bvalid, 1'b0);
    checkOutput("mid_rst_hold", o_cpu_rst_hold, 1'b0);
    step();
    p0 = pulses;
    applyStimulus(32'h504, 32'h7777_1234, 4'hF, 1, resp, ok);
    checkOutput("post_rst_done", ok, 1'b1);
    checkOutput("post_rst_bresp", resp, 2'b00);
    checkOutput("post_rst_pulses", pulses - p0, 1);
    checkOutput("post_rst_addr", last_addr, 32'h504);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
